// File: rtl/scan_coord_ctrl.sv
// Raster/serpentine (x, y) coordinate sequencer; serpentine rows compiled in with SCAN_SERPENTINE_EN.
// Latency: (0,0) is presented one cycle after start; then one coordinate per cycle with no row bubbles.
// Backpressure: coord_valid stays high and x, y and the flags hold while coord_ready is low.
module scan_coord_ctrl #(
    parameter int X_W = 10,
    parameter int Y_W = 10
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           start,
    input  logic           abort,
    input  logic [X_W-1:0] img_w,
    input  logic [Y_W-1:0] img_h,
    input  logic           coord_ready,
    output logic           coord_valid,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           first_px,
    output logic           last_px,
    output logic           scan_dir,
    output logic           busy,
    output logic           done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] r_w_last;
    logic [Y_W-1:0] r_h_last;
    logic           w_dir;
    logic           w_row_end;
    logic           w_last_row;
    logic           w_scan;

    assign w_scan     = (r_state == ST_SCAN);
    assign w_row_end  = w_dir ? (r_x == '0) : (r_x == r_w_last);
    assign w_last_row = (r_y == r_h_last);

`ifdef SCAN_SERPENTINE_EN
    logic r_dir;

    // Direction flips on every row change so odd rows run right-to-left.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dir <= 1'b0;
        end else if (!abort) begin
            if (r_state == ST_IDLE && start) begin
                r_dir <= 1'b0;
            end else if (w_scan && coord_ready && w_row_end && !w_last_row) begin
                r_dir <= ~r_dir;
            end
        end
    end

    assign w_dir = r_dir;
`else
    assign w_dir = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_w_last <= '0;
            r_h_last <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_w_last <= img_w;
                        r_h_last <= img_h;
                        r_x      <= '0;
                        r_y      <= '0;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (coord_ready) begin
                        if (!w_row_end) begin
                            r_x <= w_dir ? (r_x - 1'b1) : (r_x + 1'b1);
                        end else if (!w_last_row) begin
                            r_y <= r_y + 1'b1;
`ifndef SCAN_SERPENTINE_EN
                            r_x <= '0;
`endif
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; no input reaches an output combinationally.
    assign coord_valid = w_scan;
    assign x_out       = r_x;
    assign y_out       = r_y;
    assign first_px    = w_scan && (r_x == '0) && (r_y == '0);
    assign last_px     = w_scan && w_last_row && w_row_end;
    assign scan_dir    = w_dir;
    assign busy        = (r_state == ST_SCAN) || (r_state == ST_DONE);
    assign done        = (r_state == ST_DONE);

endmodule
